alu_reservation_station: RTL and testbench
==========================================

// Module: alu_reservation_station
// PURPOSE
//   Reservation station directly upstream of the ALU in the Tomasulo core.
//   Buffers issued integer/branch/jump ops until both operands are known.
//   Snoops the ALU and LSB broadcast buses to capture pending operands.
//   Dispatches at most one ready op per cycle on registered outputs that drive the ALU input ports.
// PARAMETERS
//   RS_SIZE  16  number of entries; power of two
//   RS_W     4   log2(RS_SIZE)
//   ROB_W    4   ROB tag width; must match `ENTRY_RANGE
// PORTS
//   clk            in   1   clock
//   rst            in   1   synchronous reset, active-high
//   rdy            in   1   global enable; low = freeze all state
//   rollback       in   1   mispredict flush
//   issue_valid    in   1   decoder issues one op this cycle
//   issue_op       in   6   opcode (`ADD .. `AUIPC from operaType.v)
//   issue_inst     in   32  raw instruction (ALU takes shamt from [24:20])
//   issue_vj/vk    in   32  operand values, valid when the matching q*_busy is 0
//   issue_qj_busy  in   1   vj pending; issue_qj (ROB_W) = producer tag
//   issue_qk_busy  in   1   vk pending; issue_qk (ROB_W) = producer tag
//   issue_pc/imm   in   32  pc and sign-extended immediate
//   issue_entry    in   ROB_W  destination ROB tag
//   rs_full        out  1   combinational: no free entry
//   alu_broadcast  in   1   ALU result valid; alu_result 32, alu_entry ROB_W
//   lsb_broadcast  in   1   LSB result valid; lsb_result 32, lsb_entry ROB_W
//   new_calculate  out  1   one-cycle dispatch strobe to ALU
//   op/instruction/vj/vk/pc/imm/entry  out  6/32/32/32/32/32/ROB_W  registered ALU operands
// BEHAVIOUR
//   Reset: every entry busy=0; all outputs 0; rs_full=0.
//   rdy=0: no state change; new_calculate<=0; other outputs hold.
//   rollback=1 (rdy=1): all busy<=0, new_calculate<=0; same-cycle issue and dispatch are dropped.
//   Issue: written into the lowest-index free entry, judged on pre-edge busy.
//     A slot freed by dispatch in the same cycle is not reused until the next cycle.
//     issue_valid while rs_full is illegal: ignored, flagged by a bench assertion.
//   Issue bypass: if issue_qj_busy and a broadcast this cycle matches issue_qj,
//     store its result with qj_busy=0; likewise for k. The ALU bus wins if both match (illegal).
//   Wakeup: every busy entry with qj_busy and qj==alu_entry (alu_broadcast) takes vj<=alu_result
//     and qj_busy<=0; same for LSB and for k. Both operands may wake in one cycle.
//   Ready = busy & ~qj_busy & ~qk_busy, from registered state only; a wakeup this cycle dispatches next cycle at the earliest.
//   Dispatch: lowest-index ready entry; its fields are latched to the outputs, new_calculate<=1, busy<=0.
//     No ready entry: new_calculate<=0; payload outputs hold.
//   Latency: an op issued with both operands ready at edge N appears at the ALU after edge N+1.
//   new_calculate is never high two cycles for the same entry.
//   Ops ignoring vk (I/U/J types) issue with qk_busy=0. The RS never inspects op.
// STRUCTURE
//   Shared header operaType.v: opcode macros, `ENTRY_RANGE, add `RS_SIZE / `RS_RANGE.
//   Sub-module rs_first_set: RS_SIZE-bit priority encoder giving {found, index}.
//     Instantiated twice, once for the free mask and once for the ready mask.
//   Entry storage: per-field reg arrays; one always @(posedge clk) block for state and outputs.
// TESTING
//   1 Reset, then issue ADD vj=5 vk=7 entry=3 with no pending operand
//     -> new_calculate=1 for exactly 1 cycle, 2 edges after issue, with vj=5 vk=7 entry=3.
//   2 Issue SUB qj_busy qj=2; two cycles later alu_broadcast entry=2 result=0x10
//     -> dispatch the cycle after the broadcast with vj=0x10.
//   3 Issue with qk=6 while lsb_broadcast entry=6 result=0xFF in the same cycle
//     -> stored ready; dispatched next cycle with vk=0xFF.
//   4 Issue 16 ops all pending -> rs_full=1. Wake entry 0 -> it dispatches and rs_full falls.
//     The next issue lands in entry 0 one cycle later, never in the freeing cycle.
//   5 Two ready entries 1 and 4 -> entry 1 dispatched first, entry 4 next cycle, strobes back-to-back.
//   6 Fill 5 entries, assert rollback with a concurrent issue -> no strobe afterward, rs_full=0, all entries empty.
//     Hold rdy=0 mid-dispatch -> outputs frozen, new_calculate=0.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared sizes and entry payload layout for the ALU reservation station.
package alu_reservation_station_pkg;

  localparam int unsigned RS_SIZE = 16;
  localparam int unsigned RS_W    = 4;
  localparam int unsigned ROB_W   = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned XLEN    = 32;

  // Fields copied verbatim from issue to dispatch; the RS never interprets them.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  inst;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [ROB_W-1:0] entry;
  } rs_payload_t;

endpackage

// File: rtl/alu_reservation_station_first_set.sv
// Lowest-index-first priority encoder returning {found, index}.
module rs_first_set #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input  logic [N-1:0] mask,
  output logic         found,
  output logic [W-1:0] index
);

  // Scan high to low so the lowest set bit is the final assignment.
  always_comb begin
    found = |mask;
    index = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask[i]) index = W'(i);
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station feeding the ALU: buffers issued ops, snoops ALU/LSB
// broadcasts for pending operands and dispatches one ready op per cycle.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             issue_valid,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [XLEN-1:0]  issue_inst,
  input  logic [XLEN-1:0]  issue_vj,
  input  logic [XLEN-1:0]  issue_vk,
  input  logic             issue_qj_busy,
  input  logic [ROB_W-1:0] issue_qj,
  input  logic             issue_qk_busy,
  input  logic [ROB_W-1:0] issue_qk,
  input  logic [XLEN-1:0]  issue_pc,
  input  logic [XLEN-1:0]  issue_imm,
  input  logic [ROB_W-1:0] issue_entry,
  output logic             rs_full,
  input  logic             alu_broadcast,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [ROB_W-1:0] alu_entry,
  input  logic             lsb_broadcast,
  input  logic [XLEN-1:0]  lsb_result,
  input  logic [ROB_W-1:0] lsb_entry,
  output logic             new_calculate,
  output logic [OP_W-1:0]  op,
  output logic [XLEN-1:0]  instruction,
  output logic [XLEN-1:0]  vj,
  output logic [XLEN-1:0]  vk,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  imm,
  output logic [ROB_W-1:0] entry
);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_busy;
  logic [RS_SIZE-1:0] qk_busy;
  logic [ROB_W-1:0]   qj_tag  [RS_SIZE];
  logic [ROB_W-1:0]   qk_tag  [RS_SIZE];
  logic [XLEN-1:0]    vj_val  [RS_SIZE];
  logic [XLEN-1:0]    vk_val  [RS_SIZE];
  rs_payload_t        payload [RS_SIZE];

  logic               free_found;
  logic               ready_found;
  logic [RS_W-1:0]    free_idx;
  logic [RS_W-1:0]    ready_idx;
  logic [RS_SIZE-1:0] free_mask;
  logic [RS_SIZE-1:0] ready_mask;

  assign free_mask  = ~busy;
  assign ready_mask = busy & ~qj_busy & ~qk_busy;
  assign rs_full    = ~free_found;

  rs_first_set #(.N(RS_SIZE), .W(RS_W)) u_free_sel (
    .mask  (free_mask),
    .found (free_found),
    .index (free_idx)
  );

  rs_first_set #(.N(RS_SIZE), .W(RS_W)) u_ready_sel (
    .mask  (ready_mask),
    .found (ready_found),
    .index (ready_idx)
  );

  // Issue-time bypass: a result broadcast in the issue cycle is captured directly.
  logic            alu_hit_j, lsb_hit_j, alu_hit_k, lsb_hit_k;
  logic            issue_qj_pend, issue_qk_pend;
  logic [XLEN-1:0] issue_vj_byp, issue_vk_byp;

  always_comb begin
    alu_hit_j     = issue_qj_busy & alu_broadcast & (issue_qj == alu_entry);
    lsb_hit_j     = issue_qj_busy & lsb_broadcast & (issue_qj == lsb_entry);
    alu_hit_k     = issue_qk_busy & alu_broadcast & (issue_qk == alu_entry);
    lsb_hit_k     = issue_qk_busy & lsb_broadcast & (issue_qk == lsb_entry);
    issue_qj_pend = issue_qj_busy & ~alu_hit_j & ~lsb_hit_j;
    issue_qk_pend = issue_qk_busy & ~alu_hit_k & ~lsb_hit_k;
    issue_vj_byp  = alu_hit_j ? alu_result : (lsb_hit_j ? lsb_result : issue_vj);
    issue_vk_byp  = alu_hit_k ? alu_result : (lsb_hit_k ? lsb_result : issue_vk);
  end

  // Entry state and registered ALU operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= '0;
      new_calculate <= 1'b0;
      op            <= '0;
      instruction   <= '0;
      vj            <= '0;
      vk            <= '0;
      pc            <= '0;
      imm           <= '0;
      entry         <= '0;
    end else if (rdy) begin
      if (rollback) begin
        busy          <= '0;
        new_calculate <= 1'b0;
      end else begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (busy[i] && qj_busy[i]) begin
            if (alu_broadcast && qj_tag[i] == alu_entry) begin
              vj_val[i]  <= alu_result;
              qj_busy[i] <= 1'b0;
            end else if (lsb_broadcast && qj_tag[i] == lsb_entry) begin
              vj_val[i]  <= lsb_result;
              qj_busy[i] <= 1'b0;
            end
          end
          if (busy[i] && qk_busy[i]) begin
            if (alu_broadcast && qk_tag[i] == alu_entry) begin
              vk_val[i]  <= alu_result;
              qk_busy[i] <= 1'b0;
            end else if (lsb_broadcast && qk_tag[i] == lsb_entry) begin
              vk_val[i]  <= lsb_result;
              qk_busy[i] <= 1'b0;
            end
          end
        end

        new_calculate <= ready_found;
        if (ready_found) begin
          op              <= payload[ready_idx].op;
          instruction     <= payload[ready_idx].inst;
          vj              <= vj_val[ready_idx];
          vk              <= vk_val[ready_idx];
          pc              <= payload[ready_idx].pc;
          imm             <= payload[ready_idx].imm;
          entry           <= payload[ready_idx].entry;
          busy[ready_idx] <= 1'b0;
        end

        // free_idx is never the dispatched slot, so a freed slot waits a cycle.
        if (issue_valid && free_found) begin
          busy[free_idx]    <= 1'b1;
          qj_busy[free_idx] <= issue_qj_pend;
          qk_busy[free_idx] <= issue_qk_pend;
          qj_tag[free_idx]  <= issue_qj;
          qk_tag[free_idx]  <= issue_qk;
          vj_val[free_idx]  <= issue_vj_byp;
          vk_val[free_idx]  <= issue_vk_byp;
          payload[free_idx] <= '{op: issue_op, inst: issue_inst, pc: issue_pc,
                                 imm: issue_imm, entry: issue_entry};
        end
      end
    end else begin
      new_calculate <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Randomized and directed bench for alu_reservation_station against a slot-level reference model.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, rollback, issue_valid;
  logic [5:0]  issue_op;
  logic [31:0] issue_inst, issue_vj, issue_vk, issue_pc, issue_imm;
  logic        issue_qj_busy, issue_qk_busy;
  logic [3:0]  issue_qj, issue_qk, issue_entry;
  logic        rs_full;
  logic        alu_broadcast, lsb_broadcast;
  logic [31:0] alu_result, lsb_result;
  logic [3:0]  alu_entry, lsb_entry;
  logic        new_calculate;
  logic [5:0]  op;
  logic [31:0] instruction, vj, vk, pc, imm;
  logic [3:0]  entry;

  alu_reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_inst(issue_inst),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qj(issue_qj),
    .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_entry(issue_entry),
    .rs_full(rs_full),
    .alu_broadcast(alu_broadcast), .alu_result(alu_result), .alu_entry(alu_entry),
    .lsb_broadcast(lsb_broadcast), .lsb_result(lsb_result), .lsb_entry(lsb_entry),
    .new_calculate(new_calculate), .op(op), .instruction(instruction),
    .vj(vj), .vk(vk), .pc(pc), .imm(imm), .entry(entry)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one record per slot, outputs as last dispatched.
  typedef struct {
    bit          busy;
    bit          qjp;
    bit          qkp;
    logic [3:0]  qj, qk, ent;
    logic [31:0] vj, vk, inst, pc, imm;
    logic [5:0]  op;
  } slot_t;

  slot_t       m [16];
  bit          m_nc;
  logic [5:0]  m_op;
  logic [31:0] m_inst, m_vj, m_vk, m_pc, m_imm;
  logic [3:0]  m_ent;

  function automatic bit m_full();
    foreach (m[i]) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Does a pending operand with this tag see a broadcast now? ALU takes priority.
  function automatic bit bus_hit(input bit pend, input logic [3:0] tag, output logic [31:0] val);
    val = '0;
    if (!pend) return 1'b0;
    if (alu_broadcast && tag == alu_entry) begin val = alu_result; return 1'b1; end
    if (lsb_broadcast && tag == lsb_entry) begin val = lsb_result; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_edge();
    int r, f;
    logic [31:0] v;
    slot_t s;
    r = -1;
    f = -1;
    if (rst) begin
      foreach (m[i]) m[i].busy = 1'b0;
      m_nc = 0; m_op = '0; m_inst = '0; m_vj = '0; m_vk = '0; m_pc = '0; m_imm = '0; m_ent = '0;
    end else if (!rdy) begin
      m_nc = 0;
    end else if (rollback) begin
      foreach (m[i]) m[i].busy = 1'b0;
      m_nc = 0;
    end else begin
      foreach (m[i]) begin
        if (r < 0 && m[i].busy && !m[i].qjp && !m[i].qkp) r = i;
        if (f < 0 && !m[i].busy) f = i;
      end
      m_nc = (r >= 0);
      if (r >= 0) begin
        m_op = m[r].op; m_inst = m[r].inst; m_vj = m[r].vj; m_vk = m[r].vk;
        m_pc = m[r].pc; m_imm = m[r].imm; m_ent = m[r].ent;
      end
      foreach (m[i]) if (m[i].busy) begin
        if (bus_hit(m[i].qjp, m[i].qj, v)) begin m[i].vj = v; m[i].qjp = 0; end
        if (bus_hit(m[i].qkp, m[i].qk, v)) begin m[i].vk = v; m[i].qkp = 0; end
      end
      if (r >= 0) m[r].busy = 1'b0;
      if (issue_valid && f >= 0) begin
        s.busy = 1; s.qjp = issue_qj_busy; s.qkp = issue_qk_busy;
        s.qj = issue_qj; s.qk = issue_qk; s.vj = issue_vj; s.vk = issue_vk;
        s.op = issue_op; s.inst = issue_inst; s.pc = issue_pc; s.imm = issue_imm; s.ent = issue_entry;
        if (bus_hit(s.qjp, s.qj, v)) begin s.vj = v; s.qjp = 0; end
        if (bus_hit(s.qkp, s.qk, v)) begin s.vk = v; s.qkp = 0; end
        m[f] = s;
      end
    end
  endtask

  task automatic idle();
    rdy = 1; rollback = 0; issue_valid = 0; alu_broadcast = 0; lsb_broadcast = 0;
  endtask

  task automatic put(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                     input bit jb, input logic [3:0] jt, input bit kb, input logic [3:0] kt,
                     input logic [3:0] e);
    issue_valid = 1; issue_op = o; issue_vj = a; issue_vk = b;
    issue_qj_busy = jb; issue_qj = jt; issue_qk_busy = kb; issue_qk = kt; issue_entry = e;
    issue_inst = $urandom; issue_pc = $urandom; issue_imm = $urandom;
  endtask

  // One clock: model steps on the same inputs the DUT samples, then all outputs are compared.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("new_calculate", new_calculate, m_nc);
    check_eq("rs_full", rs_full, m_full());
    check_eq("op", op, m_op);
    check_eq("instruction", instruction, m_inst);
    check_eq("vj", vj, m_vj);
    check_eq("vk", vk, m_vk);
    check_eq("pc", pc, m_pc);
    check_eq("imm", imm, m_imm);
    check_eq("entry", entry, m_ent);
    idle();
  endtask

  always @(posedge clk)
    if (!rst && rdy && !rollback && issue_valid && rs_full) $error("FAIL issue_while_full");

  initial begin
    issue_op = '0; issue_inst = '0; issue_vj = '0; issue_vk = '0; issue_pc = '0; issue_imm = '0;
    issue_qj_busy = 0; issue_qk_busy = 0; issue_qj = '0; issue_qk = '0; issue_entry = '0;
    alu_result = '0; lsb_result = '0; alu_entry = '0; lsb_entry = '0;
    foreach (m[i]) m[i] = '{default: '0};
    idle();
    rst = 1; tick(); tick(); rst = 0;
    check_eq("reset_nc", new_calculate, 0);
    check_eq("reset_full", rs_full, 0);

    // Ready ADD: strobe two edges after issue, exactly one cycle.
    put(6'd1, 32'd5, 32'd7, 0, 4'd0, 0, 4'd0, 4'd3); tick();
    check_eq("s1_not_yet", new_calculate, 0);
    tick();
    check_eq("s1_strobe", new_calculate, 1);
    check_eq("s1_vj", vj, 32'd5);
    check_eq("s1_vk", vk, 32'd7);
    check_eq("s1_entry", entry, 4'd3);
    tick();
    check_eq("s1_one_cycle", new_calculate, 0);

    // SUB waiting on tag 2, woken by the ALU two cycles later.
    put(6'd2, 32'd0, 32'd1, 1, 4'd2, 0, 4'd0, 4'd4); tick(); tick();
    alu_broadcast = 1; alu_entry = 4'd2; alu_result = 32'h10; tick();
    check_eq("s2_wake_no_dispatch", new_calculate, 0);
    tick();
    check_eq("s2_strobe", new_calculate, 1);
    check_eq("s2_vj", vj, 32'h10);

    // Issue-cycle bypass from the LSB bus.
    put(6'd3, 32'd9, 32'd0, 0, 4'd0, 1, 4'd6, 4'd7);
    lsb_broadcast = 1; lsb_entry = 4'd6; lsb_result = 32'hFF; tick();
    tick();
    check_eq("s3_strobe", new_calculate, 1);
    check_eq("s3_vk", vk, 32'hFF);

    // Fill all 16 slots pending on tag == slot index, then free slot 0.
    for (int i = 0; i < 16; i++) begin
      put(6'd1, 32'd0, 32'd1, 1, 4'(i), 0, 4'd0, 4'(i)); tick();
    end
    check_eq("s4_full", rs_full, 1);
    alu_broadcast = 1; alu_entry = 4'd0; alu_result = 32'h55; tick();
    check_eq("s4_still_full", rs_full, 1);
    tick();
    check_eq("s4_dispatch0", new_calculate, 1);
    check_eq("s4_entry0", entry, 4'd0);
    check_eq("s4_not_full", rs_full, 0);
    put(6'd1, 32'd1, 32'd2, 0, 4'd0, 0, 4'd0, 4'hA); tick();
    check_eq("s4_refilled", rs_full, 1);
    tick();
    check_eq("s4_new_op", entry, 4'hA);
    rollback = 1; tick();

    // Slots 1 and 4 wake together; dispatch in index order, back to back.
    for (int i = 0; i < 5; i++) begin
      put(6'd4, 32'd0, 32'd0, 1, 4'(10 + i), 0, 4'd0, 4'(i)); tick();
    end
    alu_broadcast = 1; alu_entry = 4'd11; alu_result = 32'h11;
    lsb_broadcast = 1; lsb_entry = 4'd14; lsb_result = 32'h14; tick();
    tick();
    check_eq("s5_first", entry, 4'd1);
    tick();
    check_eq("s5_second_nc", new_calculate, 1);
    check_eq("s5_second", entry, 4'd4);
    tick();

    // Rollback with concurrent issue drops everything.
    for (int i = 0; i < 5; i++) begin
      put(6'd5, 32'd0, 32'd0, 1, 4'd7, 0, 4'd0, 4'(i)); tick();
    end
    rollback = 1; put(6'd1, 32'd1, 32'd1, 0, 4'd0, 0, 4'd0, 4'd9); tick();
    check_eq("s6_empty", rs_full, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("s6_no_strobe", new_calculate, 0);
    end

    // rdy low freezes a pending dispatch.
    put(6'd6, 32'h77, 32'h88, 0, 4'd0, 0, 4'd0, 4'd5); tick();
    rdy = 0; tick();
    check_eq("s6_frozen_nc", new_calculate, 0);
    rdy = 0; tick();
    tick();
    check_eq("s6_resume", new_calculate, 1);
    check_eq("s6_resume_vj", vj, 32'h77);
    rdy = 0; tick();
    check_eq("s6_hold_vj", vj, 32'h77);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(9) != 0);
      rollback = ($urandom_range(39) == 0);
      if (!m_full() && $urandom_range(1) == 1)
        put(6'($urandom), $urandom, $urandom, 1'($urandom), 4'($urandom),
            1'($urandom), 4'($urandom), 4'($urandom));
      alu_broadcast = 1'($urandom); alu_entry = 4'($urandom); alu_result = $urandom;
      lsb_broadcast = 1'($urandom); lsb_entry = 4'($urandom); lsb_result = $urandom;
      if (alu_broadcast && lsb_entry == alu_entry) lsb_entry = alu_entry + 4'd1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
